// File: rtl/pool_pkg.sv
// Shared types and arithmetic helpers for the streaming 2x2 pooling datapath.
// Callers sign-extend operands to POOL_MAXW and size-cast the result back to lane width.
package pool_pkg;

  typedef enum logic {
    POOL_MAX = 1'b0,
    POOL_AVG = 1'b1
  } pool_mode_e;

  localparam int unsigned POOL_MAXW = 64;

  typedef logic signed [POOL_MAXW-1:0] pool_wide_t;

  function automatic pool_wide_t smax(input pool_wide_t a, input pool_wide_t b);
    return (a > b) ? a : b;
  endfunction

  // Arithmetic shift gives floor division by 4 for negative sums.
  function automatic pool_wide_t avg4(input pool_wide_t sum);
    return sum >>> 2;
  endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Row buffer holding one horizontally pooled row (synchronous write, combinational read).
module pool_line_buf #(
  parameter int unsigned DEPTH = 5,
  parameter int unsigned DW    = 66,
  parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/maxpool_stream.sv
// Streaming 2x2 / stride-2 max or average pooling over raster-order pixels,
// all channels in parallel, with a registered valid/ready output.
module maxpool_stream
  import pool_pkg::*;
#(
  parameter int unsigned BW    = 32,
  parameter int unsigned CH    = 2,
  parameter int unsigned IMG_W = 10,
  parameter int unsigned IMG_H = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [CH*BW-1:0] in_data,
  input  logic            mode,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [CH*BW-1:0] out_data,
  output logic            frame_done
);

  localparam int unsigned CW    = (IMG_W > 2) ? $clog2(IMG_W) : 1;
  localparam int unsigned RW    = (IMG_H > 2) ? $clog2(IMG_H) : 1;
  localparam int unsigned DEPTH = IMG_W / 2;
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LW    = BW + 1;

  logic [CW-1:0]       col_q;
  logic [RW-1:0]       row_q;
  logic [CH*BW-1:0]    h_q;
  pool_mode_e          mode_q;
  logic                out_last_q;

  logic                acc;
  logic                rb_we;
  logic                load;
  logic [AW-1:0]       rb_addr;
  logic [CH*LW-1:0]    h_lanes;
  logic [CH*LW-1:0]    rb_rdata;
  logic [CH*BW-1:0]    win;

  logic [BW-1:0]       px;
  logic [BW-1:0]       hq;
  logic signed [LW-1:0] hl;
  logic signed [LW-1:0] el;

  function automatic pool_wide_t sext_bw(input logic [BW-1:0] x);
    return pool_wide_t'({{(POOL_MAXW-BW){x[BW-1]}}, x});
  endfunction

  function automatic pool_wide_t sext_lw(input logic [LW-1:0] x);
    return pool_wide_t'({{(POOL_MAXW-LW){x[LW-1]}}, x});
  endfunction

  assign in_ready = !out_valid || out_ready;
  assign acc      = in_valid && in_ready;
  assign rb_we    = acc && col_q[0] && !row_q[0];
  assign load     = acc && col_q[0] && row_q[0];
  assign rb_addr  = AW'(col_q >> 1);

  pool_line_buf #(
    .DEPTH (DEPTH),
    .DW    (CH*LW),
    .AW    (AW)
  ) u_line_buf (
    .clk   (clk),
    .we    (rb_we),
    .waddr (rb_addr),
    .wdata (h_lanes),
    .raddr (rb_addr),
    .rdata (rb_rdata)
  );

  // Horizontal pair op feeds both the row buffer (even rows) and the window op (odd rows).
  always_comb begin
    h_lanes = '0;
    win     = '0;
    px      = '0;
    hq      = '0;
    hl      = '0;
    el      = '0;
    for (int unsigned c = 0; c < CH; c++) begin
      px = in_data[c*BW +: BW];
      hq = h_q[c*BW +: BW];
      if (mode_q == POOL_AVG) hl = LW'(sext_bw(hq) + sext_bw(px));
      else                    hl = LW'(smax(sext_bw(hq), sext_bw(px)));
      h_lanes[c*LW +: LW] = hl;
      el = rb_rdata[c*LW +: LW];
      if (mode_q == POOL_AVG) win[c*BW +: BW] = BW'(avg4(sext_lw(el) + sext_lw(hl)));
      else                    win[c*BW +: BW] = BW'(smax(sext_lw(el), sext_lw(hl)));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q      <= '0;
      row_q      <= '0;
      h_q        <= '0;
      mode_q     <= POOL_MAX;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last_q <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= out_valid && out_ready && out_last_q;
      if (acc) begin
        if (col_q == CW'(IMG_W-1)) begin
          col_q <= '0;
          row_q <= (row_q == RW'(IMG_H-1)) ? '0 : row_q + RW'(1);
        end else begin
          col_q <= col_q + CW'(1);
        end
        if (!col_q[0]) h_q <= in_data;
        if (col_q == '0 && row_q == '0) mode_q <= pool_mode_e'(mode);
      end
      if (load) begin
        out_data   <= win;
        out_valid  <= 1'b1;
        out_last_q <= (row_q == RW'(IMG_H-1)) && (col_q == CW'(IMG_W-1));
      end else if (out_ready) begin
        out_valid  <= 1'b0;
      end
    end
  end

endmodule
